// File: rtl/layer0_lut_prog.sv
// layer0_lut_prog: serially programmed lookup table with a trailing parity word.
// A load streams 2**ADDR_W entries (address 0 first) followed by one parity word
// equal to the XOR of all entries; a matching parity arms the table for
// single-cycle registered lookups on M0 -> M1.
// Optional feature: define LUT_READBACK_EN to add the rb_req/rb_bit/rb_valid
// readback port that streams the whole table out in RUN.
module layer0_lut_prog #(
    parameter int ADDR_W = 6,
    parameter int OUT_W  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_start,
    input  logic [OUT_W-1:0]  cfg_bit,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [ADDR_W-1:0] M0,
    input  logic              in_valid,
    output logic [OUT_W-1:0]  M1,
    output logic              out_valid,
    output logic              loaded,
    output logic              err,
`ifdef LUT_READBACK_EN
    input  logic              rb_req,
    output logic [OUT_W-1:0]  rb_bit,
    output logic              rb_valid,
`endif
    output logic              busy
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] CNT_ONE = 1;

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    state_t             state;
    logic [OUT_W-1:0]   tbl [DEPTH];
    logic [ADDR_W:0]    cnt;
    logic               armed;
    logic               start;
    logic               xfer;
    logic [OUT_W-1:0]   xor_all;

    // The first edge after reset release only arms the block; inputs are ignored.
    assign start = cfg_start & armed;
    // cfg_start wins over a coinciding transfer, which is then discarded.
    assign xfer  = cfg_valid & cfg_ready & ~start;

    // Arm input processing one cycle after reset is released.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values, independent of block ordering.
        if (rst) armed <= 1'b0;
        else     armed <= 1'b1;
    end

    // Running parity over the current table image; after a full load every
    // entry has been rewritten, so this is the XOR of this load's entries.
    always_comb begin
        // NOTE: a default before the loop keeps this purely combinational (no latch).
        xor_all = '0;
        for (int i = 0; i < DEPTH; i++) xor_all = xor_all ^ tbl[i];
    end

    // Load controller: state, write counter, table writes, status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            cfg_ready <= 1'b0;
            loaded    <= 1'b0;
            err       <= 1'b0;
            // NOTE: the table is a register array, so it is cleared on reset like
            // any other state; a RAM macro would not allow this.
            for (int i = 0; i < DEPTH; i++) tbl[i] <= '0;
        end else if (start) begin
            state     <= LOAD;
            cnt       <= '0;
            cfg_ready <= 1'b1;
            loaded    <= 1'b0;
            err       <= 1'b0;
        end else if (xfer) begin
            if (!cnt[ADDR_W]) begin
                tbl[cnt[ADDR_W-1:0]] <= cfg_bit;
                cnt                  <= cnt + CNT_ONE;
            end else begin
                // Transfer 2**ADDR_W is the parity word; table is kept either way.
                cfg_ready <= 1'b0;
                if (cfg_bit == xor_all) begin
                    loaded <= 1'b1;
                    state  <= RUN;
                end else begin
                    err    <= 1'b1;
                    state  <= IDLE;
                end
            end
        end
    end

    // Lookup pipeline: one registered result per cycle while RUN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            M1        <= '0;
            out_valid <= 1'b0;
        end else if (state == RUN && in_valid && !start) begin
            M1        <= tbl[M0];
            out_valid <= 1'b1;
        end else begin
            out_valid <= 1'b0;
        end
    end

`ifdef LUT_READBACK_EN
    localparam logic [ADDR_W:0] RB_ONE = 1;
    logic [ADDR_W:0] rb_idx;

    // Readback streamer: table[0..DEPTH-1] on consecutive cycles after rb_req.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rb_valid <= 1'b0;
            rb_bit   <= '0;
            rb_idx   <= '0;
        end else if (start) begin
            rb_valid <= 1'b0;
        end else if (rb_valid) begin
            if (rb_idx[ADDR_W]) begin
                rb_valid <= 1'b0;
            end else begin
                rb_bit <= tbl[rb_idx[ADDR_W-1:0]];
                rb_idx <= rb_idx + RB_ONE;
            end
        end else if (rb_req && state == RUN) begin
            rb_valid <= 1'b1;
            rb_bit   <= tbl[0];
            rb_idx   <= RB_ONE;
        end
    end

    assign busy = cfg_ready | rb_valid;
`else
    // cfg_ready is high exactly while loading, so it doubles as the busy flag.
    assign busy = cfg_ready;
`endif

endmodule

// File: tb/tb_layer0_lut_prog.sv
// Self-checking bench for layer0_lut_prog (default parameters).
// Fixed lookup vectors plus directed corner sequences and randomized loads and
// lookups checked against a table-image reference model.
module tb_layer0_lut_prog;

    localparam int ADDR_W = 6;
    localparam int OUT_W  = 1;
    localparam int DEPTH  = 2 ** ADDR_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cfg_start = 1'b0;
    logic [OUT_W-1:0]  cfg_bit = '0;
    logic              cfg_valid = 1'b0;
    logic              cfg_ready;
    logic [ADDR_W-1:0] M0 = '0;
    logic              in_valid = 1'b0;
    logic [OUT_W-1:0]  M1;
    logic              out_valid;
    logic              loaded;
    logic              err;
    logic              busy;
`ifdef LUT_READBACK_EN
    logic              rb_req = 1'b0;
    logic [OUT_W-1:0]  rb_bit;
    logic              rb_valid;
`endif

    layer0_lut_prog #(.ADDR_W(ADDR_W), .OUT_W(OUT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_start (cfg_start),
        .cfg_bit   (cfg_bit),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .M0        (M0),
        .in_valid  (in_valid),
        .M1        (M1),
        .out_valid (out_valid),
        .loaded    (loaded),
        .err       (err),
`ifdef LUT_READBACK_EN
        .rb_req    (rb_req),
        .rb_bit    (rb_bit),
        .rb_valid  (rb_valid),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: image the DUT should hold, whether it is serving lookups,
    // and the value M1 should currently show.
    logic [OUT_W-1:0] stim_img  [DEPTH];
    logic [OUT_W-1:0] model_img [DEPTH];
    bit               model_run = 1'b0;
    logic [OUT_W-1:0] model_m1  = '0;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [OUT_W-1:0]  m1;
    } lk_vec_t;
    lk_vec_t vecs [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [OUT_W-1:0] stim_xor();
        logic [OUT_W-1:0] x = '0;
        for (int i = 0; i < DEPTH; i++) x ^= stim_img[i];
        return x;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        cfg_valid = 1'b0;
        in_valid = 1'b0;
        #3;
        check("rst_m1", M1, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_cfg_ready", cfg_ready, 0);
        check("rst_loaded", loaded, 0);
        check("rst_err", err, 0);
        check("rst_busy", busy, 0);
        model_run = 1'b0;
        model_m1  = '0;
        for (int i = 0; i < DEPTH; i++) model_img[i] = '0;
        tick();
        rst = 1'b0;
        // A start in the first cycle after release must be ignored.
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        check("post_rst_start_ignored", cfg_ready, 0);
    endtask

    task automatic pulse_start();
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        model_run = 1'b0;
        check("start_cfg_ready", cfg_ready, 1);
        check("start_busy", busy, 1);
        check("start_loaded_clear", loaded, 0);
        check("start_err_clear", err, 0);
    endtask

    task automatic send_word(input logic [OUT_W-1:0] b, input int gap);
        int t = 0;
        cfg_valid = 1'b0;
        repeat (gap) tick();
        cfg_valid = 1'b1;
        cfg_bit   = b;
        while (!cfg_ready && t < 20) begin
            tick();
            t++;
        end
        if (!cfg_ready) check("cfg_ready_timeout", cfg_ready, 1);
        else tick();
        cfg_valid = 1'b0;
    endtask

    // Stream stim_img and a parity word, then record the expected outcome.
    task automatic load_body(input bit good, input bit gaps);
        logic [OUT_W-1:0] par;
        par = good ? stim_xor() : ~stim_xor();
        for (int i = 0; i < DEPTH; i++)
            send_word(stim_img[i], gaps ? int'($urandom_range(0, 2)) : 0);
        send_word(par, 0);
        for (int i = 0; i < DEPTH; i++) model_img[i] = stim_img[i];
        model_run = good;
        check("load_loaded", loaded, good);
        check("load_err", err, !good);
        check("load_cfg_ready_done", cfg_ready, 0);
        check("load_busy_done", busy, 0);
    endtask

    task automatic lookup_cycle(input bit v, input logic [ADDR_W-1:0] a, input string nm);
        in_valid = v;
        M0 = a;
        tick();
        in_valid = 1'b0;
        if (v && model_run) model_m1 = model_img[a];
        check({nm, "_out_valid"}, out_valid, v && model_run);
        check({nm, "_m1"}, M1, model_m1);
    endtask

    task automatic random_image();
        for (int i = 0; i < DEPTH; i++) stim_img[i] = OUT_W'($urandom);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{6'd0,  1'b0};
        vecs[1] = '{6'd1,  1'b1};
        vecs[2] = '{6'd2,  1'b0};
        vecs[3] = '{6'd63, 1'b1};
        vecs[4] = '{6'd5,  1'b1};
        vecs[5] = '{6'd33, 1'b1};
        vecs[6] = '{6'd62, 1'b0};
        vecs[7] = '{6'd10, 1'b0};

        do_reset();

        // Good load of the alternating image; its parity is 0.
        for (int i = 0; i < DEPTH; i++) stim_img[i] = OUT_W'(i % 2);
        pulse_start();
        load_body(1'b1, 1'b0);
        check("good_parity_is_zero", stim_xor(), 0);

        // Back-to-back lookups from the fixed vector table.
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            M0 = vecs[i].addr;
            tick();
            check($sformatf("vec%0d_out_valid", i), out_valid, 1);
            check($sformatf("vec%0d_m1", i), M1, vecs[i].m1);
        end
        in_valid = 1'b0;
        model_m1 = vecs[7].m1;
        lookup_cycle(1'b0, 6'd1, "idle_hold");

        // Same image with wrong parity: error, no lookups served, M1 held.
        pulse_start();
        load_body(1'b0, 1'b0);
        lookup_cycle(1'b1, 6'd5, "bad_lookup");

        // Restart after 20 transfers, then a start colliding with a transfer.
        random_image();
        pulse_start();
        for (int i = 0; i < 20; i++) send_word(stim_img[i], 0);
        pulse_start();
        for (int i = 0; i < 10; i++) send_word(stim_img[i], 0);
        cfg_start = 1'b1;
        cfg_valid = 1'b1;
        cfg_bit   = ~stim_img[0];
        tick();
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
        check("collide_cfg_ready", cfg_ready, 1);
        load_body(1'b1, 1'b1);
        for (int a = 0; a < DEPTH; a++) lookup_cycle(1'b1, ADDR_W'(a), "restart_sweep");

        // Reset in the middle of a load.
        random_image();
        pulse_start();
        for (int i = 0; i < 30; i++) send_word(stim_img[i], 0);
        do_reset();
        for (int i = 0; i < 5; i++) lookup_cycle(1'b1, ADDR_W'($urandom), "post_rst_lookup");
        random_image();
        pulse_start();
        load_body(1'b1, 1'b1);
        for (int i = 0; i < 20; i++) lookup_cycle(1'b1, ADDR_W'($urandom), "reload_lookup");

        // Randomized loads (mostly good parity) and lookups.
        for (int n = 0; n < 6; n++) begin
            random_image();
            pulse_start();
            load_body($urandom_range(0, 3) != 0, 1'b1);
            for (int i = 0; i < 30; i++)
                lookup_cycle(1'($urandom), ADDR_W'($urandom), "rand_lookup");
        end

`ifdef LUT_READBACK_EN
        // Readback of a fresh image while lookups keep running.
        random_image();
        pulse_start();
        load_body(1'b1, 1'b0);
        rb_req = 1'b1;
        lookup_cycle(1'b1, ADDR_W'($urandom), "rb_lookup");
        rb_req = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            check($sformatf("rb_valid_%0d", i), rb_valid, 1);
            check($sformatf("rb_bit_%0d", i), rb_bit, model_img[i]);
            check($sformatf("rb_busy_%0d", i), busy, 1);
            lookup_cycle(1'b1, ADDR_W'($urandom), "rb_lookup");
        end
        check("rb_valid_end", rb_valid, 0);
        check("rb_busy_end", busy, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
